serial_rx_packet_ctrl: RTL and testbench

Packet-level controller for the asynchronous serial receiver. It gates the receiver's enable input and consumes its word strobe and parallel data. It frames incoming words as SYNC / LEN / payload / checksum packets and buffers the payload. Verified packets go to FPGA logic through a valid/ack handshake with a random-access read port. It runs in the receiver's sampling-clock domain (`serial_clk`).

---
 rtl/serial_rx_packet_ctrl_pkg.sv | 24 ++
 rtl/serial_rx_packet_ctrl_buffer.sv | 30 +++
 rtl/serial_rx_packet_ctrl.sv | 167 ++++++++++++++++
 tb/tb_serial_rx_packet_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_packet_ctrl_pkg.sv
// Shared types for the serial packet controller: FSM states, error codes and
// the default SYNC header value.
package serial_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SYNC,
    ST_WAIT_LEN,
    ST_WAIT_PAYLOAD,
    ST_WAIT_CHECKSUM,
    ST_DELIVER,
    ST_ERROR
  } t_pkt_state;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_LEN      = 2'd1,
    ERR_CHECKSUM = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } t_pkt_err;

  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

endpackage

// File: rtl/serial_rx_packet_ctrl_buffer.sv
// Payload buffer: DEPTH x BITS register file, synchronous write, asynchronous
// read, cleared by reset.
module pkt_buffer #(
  parameter int BITS  = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [BITS-1:0] wr_data_i,
  input  logic [AW-1:0]   rd_addr_i,
  output logic [BITS-1:0] rd_data_o
);

  logic [BITS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Addresses beyond DEPTH (non power-of-two depths) read as zero.
  assign rd_data_o = (int'(rd_addr_i) < DEPTH) ? mem_q[rd_addr_i] : '0;

endmodule

// File: rtl/serial_rx_packet_ctrl.sv
// Packet framing controller behind the serial receiver: SYNC / LEN / payload /
// checksum, buffered payload delivered through a valid/ack handshake.
module serial_rx_packet_ctrl
  import serial_pkt_pkg::*;
#(
  parameter int              BITS           = 8,
  parameter int              MAX_LEN        = 16,
  parameter logic [BITS-1:0] SYNC_WORD      = BITS'(DEFAULT_SYNC_WORD),
  parameter int              TIMEOUT_CYCLES = 1024,
  localparam int             LW             = $clog2(MAX_LEN + 1),
  localparam int             AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int             TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic            serial_clk,
  input  logic            in_rst,
  input  logic            in_enable,
  output logic            out_rx_enable,
  input  logic            in_rx_ready,
  input  logic            in_rx_next_word,
  input  logic [BITS-1:0] in_rx_data,
  output logic            out_busy,
  output logic            out_pkt_valid,
  output logic [LW-1:0]   out_pkt_len,
  input  logic [AW-1:0]   in_rd_addr,
  output logic [BITS-1:0] out_rd_data,
  input  logic            in_pkt_ack,
  output logic            out_error,
  output logic [1:0]      out_err_code
);

  t_pkt_state      state_q;
  t_pkt_err        err_q;
  logic            pending_q;
  logic [LW-1:0]   idx_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   pkt_len_q;
  logic [BITS-1:0] acc_q;
  logic [TW-1:0]   cnt_q;
  logic            rx_en_q;
  logic            valid_q;
  logic            error_q;

  logic [BITS-1:0] acc_d;
  logic            len_bad;
  logic            last_word;
  logic            timeout_hit;
  logic            buf_wr_en;

  assign acc_d     = acc_q + in_rx_data;
  assign len_bad   = (in_rx_data == '0) || (int'(in_rx_data) > MAX_LEN);
  assign last_word = (idx_q == len_q - 1'b1);
  // A strobe in flight takes precedence over an expiring timeout.
  assign timeout_hit = (cnt_q >= TW'(TIMEOUT_CYCLES - 1)) && !in_rx_next_word;
  assign buf_wr_en   = pending_q && in_enable && (state_q == ST_WAIT_PAYLOAD);

  pkt_buffer #(
    .BITS  (BITS),
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buffer (
    .clk_i     (serial_clk),
    .rst_i     (in_rst),
    .wr_en_i   (buf_wr_en),
    .wr_addr_i (AW'(idx_q)),
    .wr_data_i (in_rx_data),
    .rd_addr_i (in_rd_addr),
    .rd_data_o (out_rd_data)
  );

  // pending_q marks that the receiver strobed last cycle; in_rx_data is
  // only complete one edge after the strobe, so the word is consumed then.
  always_ff @(posedge serial_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q   <= ST_IDLE;
      err_q     <= ERR_NONE;
      pending_q <= 1'b0;
      idx_q     <= '0;
      len_q     <= '0;
      pkt_len_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      rx_en_q   <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      error_q <= 1'b0;
      if (state_q != ST_DELIVER && !in_enable) begin
        state_q   <= ST_IDLE;
        pending_q <= 1'b0;
        cnt_q     <= '0;
        rx_en_q   <= 1'b0;
      end else begin
        rx_en_q   <= in_enable;
        pending_q <= in_rx_next_word;
        case (state_q)
          ST_IDLE: state_q <= ST_WAIT_SYNC;
          ST_WAIT_SYNC: begin
            if (pending_q && in_rx_data == SYNC_WORD) begin
              state_q <= ST_WAIT_LEN;
              idx_q   <= '0;
              acc_q   <= '0;
              cnt_q   <= '0;
            end
          end
          ST_WAIT_LEN, ST_WAIT_PAYLOAD, ST_WAIT_CHECKSUM: begin
            if (pending_q) begin
              cnt_q <= '0;
              if (state_q == ST_WAIT_LEN) begin
                if (len_bad) begin
                  state_q <= ST_ERROR;
                  err_q   <= ERR_LEN;
                  error_q <= 1'b1;
                end else begin
                  len_q   <= LW'(in_rx_data);
                  acc_q   <= in_rx_data;
                  idx_q   <= '0;
                  state_q <= ST_WAIT_PAYLOAD;
                end
              end else if (state_q == ST_WAIT_PAYLOAD) begin
                acc_q <= acc_d;
                idx_q <= idx_q + 1'b1;
                if (last_word) state_q <= ST_WAIT_CHECKSUM;
              end else if (in_rx_data == acc_q) begin
                state_q   <= ST_DELIVER;
                valid_q   <= 1'b1;
                pkt_len_q <= len_q;
                err_q     <= ERR_NONE;
                rx_en_q   <= 1'b0;
                pending_q <= 1'b0;
              end else begin
                state_q <= ST_ERROR;
                err_q   <= ERR_CHECKSUM;
                error_q <= 1'b1;
              end
            end else if (timeout_hit) begin
              state_q <= ST_ERROR;
              err_q   <= ERR_TIMEOUT;
              error_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_DELIVER: begin
            pending_q <= 1'b0;
            rx_en_q   <= 1'b0;
            if (in_pkt_ack && valid_q) begin
              valid_q <= 1'b0;
              rx_en_q <= in_enable;
              state_q <= in_enable ? ST_WAIT_SYNC : ST_IDLE;
            end
          end
          ST_ERROR: state_q <= ST_WAIT_SYNC;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign out_rx_enable = rx_en_q;
  assign out_pkt_valid = valid_q;
  assign out_pkt_len   = pkt_len_q;
  assign out_error     = error_q;
  assign out_err_code  = err_q;
  assign out_busy      = !(state_q inside {ST_IDLE, ST_WAIT_SYNC, ST_DELIVER}) || !in_rx_ready;

endmodule

// File: tb/tb_serial_rx_packet_ctrl.sv
// Scoreboard bench for serial_rx_packet_ctrl: directed word sequences push the
// expected packet/error event; a negedge monitor pops and checks each event.
`timescale 1ns/1ps
module tb_serial_rx_packet_ctrl;

  logic       serial_clk = 1'b0;
  logic       in_rst = 1'b1;
  logic       in_enable = 1'b0;
  logic       out_rx_enable;
  logic       in_rx_ready = 1'b1;
  logic       in_rx_next_word = 1'b0;
  logic [7:0] in_rx_data = 8'h00;
  logic       out_busy;
  logic       out_pkt_valid;
  logic [4:0] out_pkt_len;
  logic [3:0] in_rd_addr = 4'd0;
  logic [7:0] out_rd_data;
  logic       in_pkt_ack = 1'b0;
  logic       out_error;
  logic [1:0] out_err_code;

  serial_rx_packet_ctrl #(
    .BITS           (8),
    .MAX_LEN        (16),
    .SYNC_WORD      (8'hA5),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .serial_clk      (serial_clk),
    .in_rst          (in_rst),
    .in_enable       (in_enable),
    .out_rx_enable   (out_rx_enable),
    .in_rx_ready     (in_rx_ready),
    .in_rx_next_word (in_rx_next_word),
    .in_rx_data      (in_rx_data),
    .out_busy        (out_busy),
    .out_pkt_valid   (out_pkt_valid),
    .out_pkt_len     (out_pkt_len),
    .in_rd_addr      (in_rd_addr),
    .out_rd_data     (out_rd_data),
    .in_pkt_ack      (in_pkt_ack),
    .out_error       (out_error),
    .out_err_code    (out_err_code)
  );

  always #20 serial_clk = ~serial_clk;

  int cyc = 0;
  always @(posedge serial_clk) cyc <= cyc + 1;

  typedef struct {
    bit              is_err;
    logic [1:0]      code;
    int              len;
    logic [2:0][7:0] d;
    int              at_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   last_proc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_pkt(input int len, input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] c);
    exp_t e;
    e.is_err = 1'b0; e.code = 2'd0; e.len = len; e.d = {c, b, a}; e.at_cyc = -1;
    return e;
  endfunction

  function automatic exp_t mk_err(input logic [1:0] code, input int at_cyc);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.len = 0; e.d = '0; e.at_cyc = at_cyc;
    return e;
  endfunction

  // Monitor: pops the scoreboard on every error pulse and every new delivery.
  exp_t held;
  logic prev_v = 1'b0;

  task automatic read_chk(input exp_t e, input string tag);
    for (int i = 0; i < e.len; i++) begin
      in_rd_addr = 4'(i);
      #1;
      chk($sformatf("%s_rd[%0d]", tag, i), out_rd_data, e.d[i]);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge serial_clk);
      if (out_error) begin
        if (sb.size() == 0) begin
          chk("unexpected_error", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("evt_is_error", 1, e.is_err);
          chk("err_code", out_err_code, e.code);
          if (e.at_cyc >= 0) chk("err_cycle", cyc, e.at_cyc);
        end
      end
      if (out_pkt_valid && !prev_v) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("evt_is_pkt", 0, e.is_err);
          chk("pkt_len", out_pkt_len, e.len);
          chk("pkt_err_code", out_err_code, 0);
          held = e;
          read_chk(e, "deliver");
        end
      end else if (out_pkt_valid && in_pkt_ack) begin
        read_chk(held, "frozen");
      end
      prev_v = out_pkt_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic send_word(input logic [7:0] w);
    @(posedge serial_clk); #1;
    in_rx_next_word = 1'b1;
    in_rx_data      = ~w;
    @(posedge serial_clk); #1;
    in_rx_next_word = 1'b0;
    in_rx_data      = w;
    @(posedge serial_clk); #1;
    last_proc = cyc;
  endtask

  task automatic send_n(input int n, input logic [7:0][7:0] w);
    for (int i = n - 1; i >= 0; i--) send_word(w[i]);
  endtask

  task automatic ack_pkt();
    @(posedge serial_clk); #1;
    in_pkt_ack = 1'b1;
    @(posedge serial_clk); #1;
    in_pkt_ack = 1'b0;
    chk("ack_valid_drop", out_pkt_valid, 0);
    chk("ack_rx_enable", out_rx_enable, in_enable);
  endtask

  initial begin
    // Reset state
    in_rx_ready = 1'b0;
    repeat (3) @(posedge serial_clk);
    #1;
    chk("rst_busy_rx_not_ready", out_busy, 1);
    in_rx_ready = 1'b1;
    #1;
    chk("rst_rx_enable", out_rx_enable, 0);
    chk("rst_busy", out_busy, 0);
    chk("rst_valid", out_pkt_valid, 0);
    chk("rst_len", out_pkt_len, 0);
    chk("rst_error", out_error, 0);
    chk("rst_code", out_err_code, 0);
    chk("rst_rd_data", out_rd_data, 0);
    in_rst = 1'b0;
    in_enable = 1'b1;
    repeat (2) @(posedge serial_clk);
    #1;
    chk("enable_rx_enable", out_rx_enable, 1);

    // Good packet
    sb.push_back(mk_pkt(3, 8'h11, 8'h22, 8'h33));
    send_n(6, {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
    chk("good_valid_latency", out_pkt_valid, 1);
    chk("good_rx_enable_off", out_rx_enable, 0);
    chk("good_busy_deliver", out_busy, 0);
    ack_pkt();

    // Bad checksum, then a good packet
    sb.push_back(mk_err(2'd2, -1));
    send_n(5, {8'hA5, 8'h02, 8'h10, 8'h20, 8'h00});
    chk("csum_err_pulse", out_error, 1);
    chk("csum_no_valid", out_pkt_valid, 0);
    @(posedge serial_clk); #1;
    chk("csum_pulse_single", out_error, 0);
    chk("csum_code_hold", out_err_code, 2);
    sb.push_back(mk_pkt(2, 8'h01, 8'h02, 8'h00));
    send_n(5, {8'hA5, 8'h02, 8'h01, 8'h02, 8'h05});
    ack_pkt();

    // Length errors
    sb.push_back(mk_err(2'd1, -1));
    send_n(2, {8'hA5, 8'h11});
    chk("len_big_err", out_error, 1);
    sb.push_back(mk_err(2'd1, -1));
    send_n(2, {8'hA5, 8'h00});
    chk("len_zero_err", out_error, 1);
    chk("len_zero_code", out_err_code, 1);

    // Timeout 64 cycles after the last processed word
    send_n(3, {8'hA5, 8'h02, 8'h55});
    sb.push_back(mk_err(2'd3, last_proc + 64));
    chk("tmo_busy_payload", out_busy, 1);
    repeat (70) @(posedge serial_clk);
    #1;
    chk("tmo_code", out_err_code, 3);
    chk("tmo_waitsync_busy", out_busy, 0);

    // Sync hunting and buffer freeze during Deliver
    sb.push_back(mk_pkt(1, 8'h7E, 8'h00, 8'h00));
    send_n(6, {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F});
    chk("hunt_valid", out_pkt_valid, 1);
    send_n(2, {8'hA5, 8'h01});
    chk("freeze_valid", out_pkt_valid, 1);
    chk("freeze_rx_enable", out_rx_enable, 0);
    ack_pkt();

    // Abort by dropping enable mid-packet
    send_n(3, {8'hA5, 8'h04, 8'h01});
    chk("abort_busy_before", out_busy, 1);
    in_enable = 1'b0;
    @(posedge serial_clk); #1;
    chk("abort_rx_enable", out_rx_enable, 0);
    chk("abort_idle_busy", out_busy, 0);
    chk("abort_no_error", out_error, 0);
    in_enable = 1'b1;
    repeat (2) @(posedge serial_clk);
    sb.push_back(mk_pkt(1, 8'h42, 8'h00, 8'h00));
    send_n(4, {8'hA5, 8'h01, 8'h42, 8'h43});
    ack_pkt();

    // Reset mid-payload
    send_n(3, {8'hA5, 8'h03, 8'h01});
    in_rst = 1'b1;
    #5;
    chk("mrst_rx_enable", out_rx_enable, 0);
    chk("mrst_busy", out_busy, 0);
    chk("mrst_valid", out_pkt_valid, 0);
    chk("mrst_len", out_pkt_len, 0);
    chk("mrst_error", out_error, 0);
    chk("mrst_rd_data", out_rd_data, 0);
    repeat (2) @(posedge serial_clk);
    in_rst = 1'b0;
    repeat (3) @(posedge serial_clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
